// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU and the two-port ALU arbiter/sequencer:
// datapath width default, ALU op-code constants and the sequencer state type.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_NOOP0 = 3'b000;
    localparam logic [2:0] OP_NOOP1 = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_SHL   = 3'b100;
    localparam logic [2:0] OP_SHR   = 3'b101;
    localparam logic [2:0] OP_ADDI  = 3'b110;
    localparam logic [2:0] OP_SUBI  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// ALU
// Purely combinational 32-bit ALU, no flags. Arithmetic wraps modulo 2^DATA_W.
// Ports:
//   op_i     : operation code (see alu_pkg OP_*)
//   in1_i    : first operand (a)
//   in2_i    : second operand (b); also the full-width shift amount
//   imm_i    : immediate for ADDI/SUBI
//   result_o : operation result (0 for both NOOP codes)
module ALU #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] in1_i,
    input  logic [DATA_W-1:0] in2_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] result_o
);
    import alu_pkg::*;

    localparam int SH_W = $clog2(DATA_W);

    // Any set bit above the low SH_W bits means the shift is >= DATA_W,
    // which must give zero rather than wrapping the shift amount.
    logic shift_big;
    assign shift_big = |in2_i[DATA_W-1:SH_W];

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = in1_i + in2_i;
            OP_SUB:  result_o = in1_i - in2_i;
            OP_SHL:  result_o = shift_big ? '0 : (in1_i << in2_i[SH_W-1:0]);
            OP_SHR:  result_o = shift_big ? '0 : (in1_i >> in2_i[SH_W-1:0]);
            OP_ADDI: result_o = in1_i + imm_i;
            OP_SUBI: result_o = in1_i - imm_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one ALU between two requesters. Round-robin grant in IDLE, operands
// latched on the request handshake, result registered in EXEC, held in RESP
// until the consumer takes it.
// Ports:
//   clk, rst_n              : clock (rising edge), async active-low reset
//   req_valid / req_ready   : per-requester valid/ready (ready is one-hot or 0)
//   req_op*/a*/b*/imm*      : per-requester operation fields
//   rsp_valid / rsp_ready   : response handshake
//   rsp_id, rsp_data        : requester tag and ALU result of the response
//   busy                    : sequencer not in IDLE
//   done_count              : responses consumed since reset (wraps)
module alu_arbiter #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2:0]        req_op0,
    input  logic [2:0]        req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [DATA_W-1:0] req_imm0,
    input  logic [DATA_W-1:0] req_imm1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [CNT_W-1:0]  done_count
);
    import alu_pkg::*;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]  done_count_q, done_count_d;

    logic              gnt_id;
    logic [DATA_W-1:0] alu_result;

    ALU #(.DATA_W(DATA_W)) u_alu (
        .op_i     (op_q),
        .in1_i    (a_q),
        .in2_i    (b_q),
        .imm_i    (imm_q),
        .result_o (alu_result)
    );

    // Round-robin: a lone requester wins; on a tie the one not granted last.
    always_comb begin
        if (req_valid == 2'b11) begin
            gnt_id = ~last_grant_q;
        end else begin
            gnt_id = req_valid[1];
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        imm_d        = imm_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        done_count_d = done_count_q;
        req_ready    = 2'b00;

        case (state_q)
            IDLE: begin
                req_ready[gnt_id] = req_valid[gnt_id];
                if (req_valid[gnt_id]) begin
                    id_d         = gnt_id;
                    last_grant_d = gnt_id;
                    op_d         = gnt_id ? req_op1  : req_op0;
                    a_d          = gnt_id ? req_a1   : req_a0;
                    b_d          = gnt_id ? req_b1   : req_b0;
                    imm_d        = gnt_id ? req_imm1 : req_imm0;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_result;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    done_count_d = done_count_q + 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= OP_NOOP0;
            a_q          <= '0;
            b_q          <= '0;
            imm_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            imm_q        <= imm_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            done_count_q <= done_count_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q != IDLE);
    assign done_count = done_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_pkg::*;

    // Narrow counter so the wrap is reached in a short run.
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2:0]    req_op0, req_op1;
    logic [31:0]   req_a0, req_a1, req_b0, req_b1, req_imm0, req_imm1;
    logic          rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0]   rsp_data;
    logic [CW-1:0] done_count;

    int total = 0;
    int bad   = 0;
    logic [CW-1:0] exp_done;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    typedef struct {
        logic        id;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(32), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .req_imm0   (req_imm0),
        .req_imm1   (req_imm1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .done_count (done_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SHL:  return (b >= 32) ? 32'd0 : (a << b);
            OP_SHR:  return (b >= 32) ? 32'd0 : (a >> b);
            OP_ADDI: return a + imm;
            OP_SUBI: return a - imm;
            default: return 32'd0;
        endcase
    endfunction

    // Scoreboard: push the model result at every request handshake, pop and
    // compare at every response handshake. Sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            sb_t  e;
            logic gid;
            if (rsp_valid && rsp_ready) begin
                $display("rsp id=%0d data=%08h", rsp_id, rsp_data);
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_id", 64'(rsp_id), 64'(e.id));
                    chk("sb_data", 64'(rsp_data), 64'(e.data));
                end
            end
            if (|(req_valid & req_ready)) begin
                gid    = req_ready[1];
                e.id   = gid;
                e.data = gid ? ref_alu(req_op1, req_a1, req_b1, req_imm1)
                             : ref_alu(req_op0, req_a0, req_b0, req_imm0);
                sb.push_back(e);
            end
        end
    end

    // An in-flight operation is dropped by reset; so is its expectation.
    always @(negedge rst_n) sb.delete();

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for acceptance, then withdraw it.
    task automatic issue(input logic id, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
        if (id) begin
            req_op1 = op; req_a1 = a; req_b1 = b; req_imm1 = imm;
        end else begin
            req_op0 = op; req_a0 = a; req_b0 = b; req_imm0 = imm;
        end
        req_valid[id] = 1'b1;
        #1;
        for (int n = 0; n < 20 && !req_ready[id]; n++) step();
        chk("issue_accepted", 64'(req_ready[id]), 64'd1);
        step();
        req_valid[id] = 1'b0;
    endtask

    // Wait (bounded) for a response with rsp_ready high and check it.
    task automatic wait_rsp(input logic exp_id, input logic [31:0] exp_data, input string tag);
        rsp_ready = 1'b1;
        for (int n = 0; n < 20 && !rsp_valid; n++) step();
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_id"}, 64'(rsp_id), 64'(exp_id));
        chk({tag, "_data"}, 64'(rsp_data), 64'(exp_data));
        step();
        exp_done = exp_done + 1'b1;
        chk({tag, "_done_count"}, 64'(done_count), 64'(exp_done));
    endtask

    initial begin
        vecs[0]  = '{OP_ADD,   32'd5,          32'd7,          32'd0,   32'd12};
        vecs[1]  = '{OP_SUB,   32'd3,          32'd5,          32'd0,   32'hFFFF_FFFE};
        vecs[2]  = '{OP_SHL,   32'd1,          32'd31,         32'd0,   32'h8000_0000};
        vecs[3]  = '{OP_SHR,   32'h8000_0000,  32'd40,         32'd0,   32'd0};
        vecs[4]  = '{OP_ADDI,  32'hFFFF_FFFF,  32'd5,          32'd1,   32'd0};
        vecs[5]  = '{OP_SUBI,  32'd0,          32'd9,          32'd1,   32'hFFFF_FFFF};
        vecs[6]  = '{OP_NOOP1, 32'hDEAD,       32'hBEEF,       32'd4,   32'd0};
        vecs[7]  = '{OP_NOOP0, 32'd1,          32'd2,          32'd3,   32'd0};
        vecs[8]  = '{OP_SHL,   32'hFFFF_FFFF,  32'd32,         32'd0,   32'd0};
        vecs[9]  = '{OP_SHR,   32'hF000_0000,  32'd4,          32'd0,   32'h0F00_0000};
        vecs[10] = '{OP_ADD,   32'h7FFF_FFFF,  32'd1,          32'd0,   32'h8000_0000};
        vecs[11] = '{OP_SUBI,  32'd10,         32'd99,         32'd3,   32'd7};

        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        req_op0 = 3'd0; req_op1 = 3'd0;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0; req_imm0 = '0; req_imm1 = '0;
        exp_done = '0;
        repeat (2) step();

        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done_count", 64'(done_count), 64'd0);
        rst_n = 1'b1;
        step();

        // Single request with exact latency: EXEC, then RESP for one cycle.
        rsp_ready = 1'b1;
        req_op0 = OP_ADD; req_a0 = 32'd5; req_b0 = 32'd7;
        req_valid = 2'b01;
        #1;
        chk("single_req_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 2'b00;
        chk("single_exec_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("single_exec_busy", 64'(busy), 64'd1);
        step();
        chk("single_resp_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("single_resp_data", 64'(rsp_data), 64'd12);
        chk("single_resp_id", 64'(rsp_id), 64'd0);
        step();
        exp_done = exp_done + 1'b1;
        chk("single_rsp_dropped", 64'(rsp_valid), 64'd0);
        chk("single_done_count", 64'(done_count), 64'd1);

        // Table vectors, alternating requesters; two passes wrap done_count.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 12; i++) begin
                issue(i[0], vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm);
                wait_rsp(i[0], vecs[i].exp, "vec");
            end
        end

        // Backpressure: last grant was requester 1, so a tie goes to 0.
        rsp_ready = 1'b0;
        req_op0 = OP_ADD; req_a0 = 32'd10; req_b0 = 32'd20;
        req_op1 = OP_SUB; req_a1 = 32'd10; req_b1 = 32'd20;
        req_valid = 2'b11;
        #1;
        chk("bp_first_grant", 64'(req_ready), 64'b01);
        step();
        step();
        for (int n = 0; n < 5; n++) begin
            chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("bp_hold_data", 64'(rsp_data), 64'd30);
            chk("bp_hold_id", 64'(rsp_id), 64'd0);
            chk("bp_hold_req_ready", 64'(req_ready), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_handshake_req_ready", 64'(req_ready), 64'd0);
        step();
        exp_done = exp_done + 1'b1;
        chk("bp_done_count", 64'(done_count), 64'(exp_done));
        chk("bp_next_grant", 64'(req_ready), 64'b10);
        step();
        req_valid = 2'b00;
        wait_rsp(1'b1, 32'hFFFF_FFF6, "bp_second");

        // Reset mid-operation: requester 0 granted last, so the post-reset
        // tie going to 0 shows last_grant was reset.
        issue(1'b0, OP_ADD, 32'd1, 32'd2, 32'd0);
        chk("midop_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        exp_done = '0;
        chk("midop_rst_busy", 64'(busy), 64'd0);
        chk("midop_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midop_rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("midop_rst_done_count", 64'(done_count), 64'd0);
        chk("midop_rst_req_ready", 64'(req_ready), 64'd0);
        step();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            chk("midop_no_rsp", 64'(rsp_valid), 64'd0);
            step();
        end

        // Tie and rotation with both requesters continuously valid.
        req_op0 = OP_SUB; req_a0 = 32'd3; req_b0 = 32'd5; req_imm0 = 32'd0;
        req_op1 = OP_SHL; req_a1 = 32'd1; req_b1 = 32'd31; req_imm1 = 32'd0;
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            wait_rsp(k[0], k[0] ? 32'h8000_0000 : 32'hFFFF_FFFE, "tie");
        end
        req_valid = 2'b00;
        repeat (4) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
